// File: rtl/sa_feed_skewer_pkg.sv
// Shared types for the systolic-array operand feed path: FSM states and lane slice placement.
// Lanes are packed MSB-first: lane 0 occupies the top DATA_WIDTH bits of a memory word.
package sa_feed_skewer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } sa_state_e;

    // Bit offset of the least significant bit of a lane inside a packed word.
    function automatic int lane_lsb(input int lane, input int dw, input int pe);
        return (pe - 1 - lane) * dw;
    endfunction

endpackage

// File: rtl/sa_feed_skewer_skew_lane.sv
// One lane of the diagonal skew: a DEPTH-stage shift register carrying {valid, data} together.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module sa_skew_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] dat_o
);

    logic [DEPTH-1:0]                 vld_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= dat_i;
            for (int s = 1; s < DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/sa_feed_skewer.sv
// Reads len consecutive operand words and feeds them to the array edge, lane i delayed i cycles.
// First lane-0 element 3 cycles after start; done pulses len+PE_SIZE+2 cycles after start.
module sa_feed_skewer
    import sa_feed_skewer_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PE_SIZE        = 16,
    parameter int MEM_ADDR_WIDTH = 7,
    parameter int LEN_WIDTH      = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic [MEM_ADDR_WIDTH-1:0]        base_addr_i,
    input  logic [LEN_WIDTH-1:0]             len_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             mem_ce_o,
    output logic [MEM_ADDR_WIDTH-1:0]        mem_addr_o,
    input  logic [DATA_WIDTH*PE_SIZE-1:0]    mem_q_i,
    output logic [DATA_WIDTH*PE_SIZE-1:0]    sa_data_o,
    output logic [PE_SIZE-1:0]               sa_valid_o
);

    localparam int MEM_DATA_WIDTH = DATA_WIDTH * PE_SIZE;
    localparam int DRAIN_W        = $clog2(PE_SIZE + 2);

    sa_state_e                 state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      word_q, word_d;
    logic [DRAIN_W-1:0]        drain_q, drain_d;
    logic                      done_q, done_d;
    logic                      rd_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            word_q   <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            word_q   <= word_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
            rd_vld_q <= (state_q == ST_READ);
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        word_d  = word_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    len_d   = len_i;
                    word_d  = '0;
                    drain_d = '0;
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (word_q == len_q - LEN_WIDTH'(1)) begin
                    word_d  = '0;
                    state_d = ST_DRAIN;
                end else begin
                    word_d = word_q + LEN_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                // PE_SIZE+1 cycles: lets the deepest lane empty before done.
                if (drain_q == DRAIN_W'(PE_SIZE)) begin
                    drain_d = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign mem_ce_o   = (state_q == ST_READ);
    assign mem_addr_o = base_q + MEM_ADDR_WIDTH'(word_q);
    assign done_o     = done_q;

    // Lane inputs are zeroed when no read data is returning so idle lanes carry zero fill.
    for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
        localparam int LSB = lane_lsb(i, DATA_WIDTH, PE_SIZE);
        logic [DATA_WIDTH-1:0] lane_dat;

        assign lane_dat = rd_vld_q ? mem_q_i[LSB +: DATA_WIDTH] : '0;

        sa_skew_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i + 1)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .vld_i (rd_vld_q),
            .dat_i (lane_dat),
            .vld_o (sa_valid_o[i]),
            .dat_o (sa_data_o[LSB +: DATA_WIDTH])
        );
    end

endmodule
